dpi_lsu: RTL and testbench

Parametrised load/store unit that fronts the DPI-C simulation memory (pmem_read/pmem_write) with a valid/ready request/response handshake.
- Adds configurable access latency, byte/half/word sizing with sign or zero extension, store byte-lane mask generation, misalignment detection and saturating access counters.
- Sits between the core's MEM stage and the simulated physical memory.
- Replaces the single-cycle always-on DPI load/store path.

---
 rtl/dpi_lsu.sv | 205 ++++++++++++++++++++
 tb/tb_dpi_lsu.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpi_lsu.sv
// Load/store unit between the MEM stage and the pmem_read/pmem_write simulation memory.
// Latency: handshake cycle to resp_valid = LATENCY+1 cycles (legal access), 1 cycle (misaligned).
// Backpressure: one access in flight; req_ready only in IDLE, response held until resp_ready.

package dpi_lsu_pmem_pkg;
    // SystemVerilog model of the simulation memory.
    // Word-addressed sparse storage plus call bookkeeping visible to the environment.
    int unsigned mem [int unsigned];
    int unsigned rd_calls;
    int unsigned wr_calls;
    int unsigned last_waddr;
    int unsigned last_wdata;
    byte unsigned last_wmask;

    function automatic void pmem_preset(input int unsigned addr, input int unsigned data);
        mem[addr] = data;
    endfunction

    function automatic void pmem_read(input int unsigned raddr, output int unsigned rdata);
        rd_calls = rd_calls + 1;
        rdata = mem.exists(raddr) ? mem[raddr] : 32'h0;
    endfunction

    function automatic void pmem_write(input int unsigned waddr, input int unsigned wdata,
                                       input byte unsigned wmask);
        int unsigned word;
        word = mem.exists(waddr) ? mem[waddr] : 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (wmask[i]) word[8*i +: 8] = wdata[8*i +: 8];
        end
        mem[waddr] = word;
        wr_calls   = wr_calls + 1;
        last_waddr = waddr;
        last_wdata = wdata;
        last_wmask = wmask;
    endfunction
endpackage

module dpi_lsu
    import dpi_lsu_pmem_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_wen,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_wdata,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic             busy,
    output logic [CNT_W-1:0] ld_cnt,
    output logic [CNT_W-1:0] st_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(LATENCY - 1);

    state_t      state;
    state_t      state_nxt;
    logic [3:0]  lat_cnt;
    logic        accept;
    logic        misaligned;
    logic        fire;

    logic [31:0] a_addr;
    logic [1:0]  a_size;
    logic        a_wen;
    logic        a_uns;
    logic [31:0] a_wdata;

    logic [31:0] aligned_addr;
    logic [3:0]  store_mask;
    logic [31:0] store_data;

    // Shift the addressed lane down and extend to 32 bits.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (size)
            2'd0:    return {{24{~uns & sh[7]}}, sh[7:0]};
            2'd1:    return {{16{~uns & sh[15]}}, sh[15:0]};
            default: return sh;
        endcase
    endfunction

    // Byte lanes touched by a store; size 3 never reaches the memory.
    function automatic logic [3:0] mask_for(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    return 4'b0001 << off;
            2'd1:    return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] mem_load(input logic [31:0] addr);
        int unsigned word;
        pmem_read(addr, word);
        return word;
    endfunction

    assign accept       = req_valid && (state == IDLE);
    assign fire         = (state == WAIT) && (lat_cnt == 4'd0);
    assign aligned_addr = {a_addr[31:2], 2'b00};
    assign store_mask   = mask_for(a_size, a_addr[1:0]);
    assign store_data   = a_wdata << {a_addr[1:0], 3'b000};

    // Alignment check on the live request, evaluated in the accept cycle.
    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = (req_addr[1:0] != 2'b00);
            2'd3:    misaligned = 1'b1;
            default: misaligned = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs; misaligned requests skip the memory wait.
    always_comb begin
        state_nxt  = state;
        req_ready  = (state == IDLE);
        resp_valid = (state == RESP);
        busy       = (state != IDLE);
        case (state)
            IDLE:    if (accept) state_nxt = misaligned ? RESP : WAIT;
            WAIT:    if (lat_cnt == 4'd0) state_nxt = RESP;
            RESP:    if (resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request payload; later input changes are ignored until IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_addr  <= '0;
            a_size  <= '0;
            a_wen   <= 1'b0;
            a_uns   <= 1'b0;
            a_wdata <= '0;
        end else if (accept) begin
            a_addr  <= req_addr;
            a_size  <= req_size;
            a_wen   <= req_wen;
            a_uns   <= req_unsigned;
            a_wdata <= req_wdata;
        end
    end

    // Access latency countdown, loaded at accept and run down in WAIT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)                                 lat_cnt <= 4'd0;
        else if (accept)                           lat_cnt <= LAT_LOAD;
        else if (state == WAIT && lat_cnt != 4'd0) lat_cnt <= lat_cnt - 4'd1;
    end

    // Exactly one memory call per legal access; response data registered alongside it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_rdata <= '0;
            resp_err   <= misaligned;
        end else if (fire) begin
            resp_err <= 1'b0;
            if (a_wen) begin
                pmem_write(aligned_addr, store_data, {4'b0000, store_mask});
                resp_rdata <= '0;
            end else begin
                resp_rdata <= load_extend(mem_load(aligned_addr), a_addr[1:0], a_size, a_uns);
            end
        end
    end

    // Saturating completion counters for legal accesses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ld_cnt <= '0;
            st_cnt <= '0;
        end else if (fire) begin
            if (a_wen) begin
                if (st_cnt != '1) st_cnt <= st_cnt + 1'b1;
            end else begin
                if (ld_cnt != '1) ld_cnt <= ld_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dpi_lsu.sv
// Bench for dpi_lsu: directed memory scenarios plus randomized traffic against a byte-level model.
// Latency: not applicable.
// Backpressure: exercises held responses and reset during an in-flight store.
module tb_dpi_lsu;
    localparam int LAT  = 2;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [31:0] BASE = 32'h8000_0000;

    logic          clock = 1'b0;
    logic          reset;
    logic          req_valid, req_ready, req_wen, req_unsigned;
    logic [31:0]   req_addr, req_wdata;
    logic [1:0]    req_size;
    logic          resp_valid, resp_ready, resp_err, busy;
    logic [31:0]   resp_rdata;
    logic [CW-1:0] ld_cnt, st_cnt;

    int checks = 0;
    int errors = 0;
    int m_ld = 0;
    int m_st = 0;
    logic [31:0] ref_mem [logic [31:0]];

    int          got_edges;
    logic [31:0] got_rdata;
    logic        got_err;

    dpi_lsu #(.LATENCY(LAT), .CNT_W(CW)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .busy(busy), .ld_cnt(ld_cnt), .st_cnt(st_cnt)
    );

    always #5 clock = ~clock;

    // ---------------- reference model ----------------
    function automatic bit ref_misaligned(input logic [31:0] addr, input int size);
        if (size == 3) return 1'b1;
        if (size == 1) return (addr % 2) != 0;
        if (size == 2) return (addr % 4) != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] addr, input int size, input bit uns);
        logic [31:0] w;
        logic [31:0] wa;
        wa = addr & ~32'h3;
        w  = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
        w  = w >> (8 * (addr % 4));
        if (size == 0) begin
            w = w & 32'hFF;
            if (!uns && w >= 32'h80) w = w | 32'hFFFF_FF00;
        end else if (size == 1) begin
            w = w & 32'hFFFF;
            if (!uns && w >= 32'h8000) w = w | 32'hFFFF_0000;
        end
        return w;
    endfunction

    task automatic ref_store(input logic [31:0] addr, input int size, input logic [31:0] wdata);
        logic [31:0] w;
        logic [31:0] wa;
        int nbytes;
        int lane;
        wa = addr & ~32'h3;
        w  = ref_mem.exists(wa) ? ref_mem[wa] : 32'h0;
        nbytes = (size == 0) ? 1 : (size == 1) ? 2 : 4;
        for (int i = 0; i < nbytes; i++) begin
            lane = int'(addr % 4) + i;
            w[8*lane +: 8] = wdata[8*i +: 8];
        end
        ref_mem[wa] = w;
    endtask

    task automatic preset(input logic [31:0] addr, input logic [31:0] data);
        ref_mem[addr] = data;
        dpi_lsu_pmem_pkg::pmem_preset(addr, data);
    endtask

    // ---------------- drivers ----------------
    // Called #1 after a rising edge with the unit idle; returns once resp_valid is seen.
    task automatic start_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL req_ready_before_req got=%b want=1", req_ready);
        end
        req_valid = 1'b1; req_wen = wen; req_addr = addr; req_size = size;
        req_unsigned = uns; req_wdata = wdata;
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_addr = $urandom(); req_wdata = $urandom();
        req_size = 2'($urandom()); req_wen = 1'($urandom()); req_unsigned = 1'($urandom());
        got_edges = 1;
        while (resp_valid !== 1'b1 && got_edges < 40) begin
            @(posedge clock); #1;
            got_edges++;
        end
        got_rdata = resp_rdata;
        got_err   = resp_err;
        checks++;
        if (resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL resp_timeout addr=%h got resp_valid=%b want=1", addr, resp_valid);
        end
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_state rdy=%b busy=%b vld=%b want 1/0/0", req_ready, busy, resp_valid);
        end
        checks++;
        if (resp_rdata !== 32'h0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp rdata=%h err=%b want 0/0", resp_rdata, resp_err);
        end
        checks++;
        if (ld_cnt !== '0 || st_cnt !== '0) begin
            errors++;
            $display("FAIL reset_counters ld=%0d st=%0d want 0/0", ld_cnt, st_cnt);
        end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_loads();
        int unsigned rd0;
        preset(BASE, 32'h8899_AABB);
        rd0 = dpi_lsu_pmem_pkg::rd_calls;
        start_req(1'b0, BASE + 3, 2'd0, 1'b0, 32'h0);
        m_ld++;
        checks++;
        if (got_edges != LAT + 1) begin
            errors++;
            $display("FAIL load_latency got=%0d want=%0d", got_edges, LAT + 1);
        end
        checks++;
        if (got_rdata !== 32'hFFFF_FF88 || got_err !== 1'b0) begin
            errors++;
            $display("FAIL load_byte_signed rdata=%h err=%b want ffffff88/0", got_rdata, got_err);
        end
        finish_resp();
        checks++;
        if (ld_cnt !== 4'd1 || dpi_lsu_pmem_pkg::rd_calls != rd0 + 1) begin
            errors++;
            $display("FAIL load_count ld=%0d reads=%0d want 1/%0d", ld_cnt,
                     dpi_lsu_pmem_pkg::rd_calls - rd0, 1);
        end
        start_req(1'b0, BASE + 2, 2'd1, 1'b1, 32'h0);
        m_ld++;
        checks++;
        if (got_rdata !== 32'h0000_8899) begin
            errors++;
            $display("FAIL load_half_unsigned got=%h want=00008899", got_rdata);
        end
        finish_resp();
        start_req(1'b0, BASE, 2'd2, 1'b0, 32'h0);
        m_ld++;
        checks++;
        if (got_rdata !== 32'h8899_AABB) begin
            errors++;
            $display("FAIL load_word got=%h want=8899aabb", got_rdata);
        end
        finish_resp();
    endtask

    task automatic test_store();
        int unsigned wr0;
        wr0 = dpi_lsu_pmem_pkg::wr_calls;
        start_req(1'b1, BASE + 1, 2'd0, 1'b0, 32'h0000_0012);
        ref_store(BASE + 1, 0, 32'h12);
        m_st++;
        checks++;
        if (got_rdata !== 32'h0 || got_err !== 1'b0) begin
            errors++;
            $display("FAIL store_resp rdata=%h err=%b want 0/0", got_rdata, got_err);
        end
        finish_resp();
        checks++;
        if (dpi_lsu_pmem_pkg::wr_calls != wr0 + 1 || dpi_lsu_pmem_pkg::last_waddr != BASE ||
            dpi_lsu_pmem_pkg::last_wdata != 32'h0000_1200 || dpi_lsu_pmem_pkg::last_wmask != 8'h02) begin
            errors++;
            $display("FAIL store_call n=%0d addr=%h data=%h mask=%h want 1/80000000/00001200/02",
                     dpi_lsu_pmem_pkg::wr_calls - wr0, dpi_lsu_pmem_pkg::last_waddr,
                     dpi_lsu_pmem_pkg::last_wdata, dpi_lsu_pmem_pkg::last_wmask);
        end
        checks++;
        if (st_cnt !== 4'd1) begin
            errors++;
            $display("FAIL store_count got=%0d want=1", st_cnt);
        end
        start_req(1'b0, BASE, 2'd2, 1'b0, 32'h0);
        m_ld++;
        checks++;
        if (got_rdata !== 32'h8899_12BB) begin
            errors++;
            $display("FAIL store_readback got=%h want=889912bb", got_rdata);
        end
        finish_resp();
    endtask

    task automatic test_misaligned();
        int unsigned rd0;
        int unsigned wr0;
        logic [31:0] addrs [3];
        logic [1:0]  sizes [3];
        addrs[0] = BASE + 1; sizes[0] = 2'd1;
        addrs[1] = BASE + 2; sizes[1] = 2'd2;
        addrs[2] = BASE;     sizes[2] = 2'd3;
        rd0 = dpi_lsu_pmem_pkg::rd_calls;
        wr0 = dpi_lsu_pmem_pkg::wr_calls;
        for (int i = 0; i < 3; i++) begin
            start_req(1'($urandom()), addrs[i], sizes[i], 1'b0, 32'hFFFF_FFFF);
            checks++;
            if (got_edges != 1 || got_err !== 1'b1 || got_rdata !== 32'h0) begin
                errors++;
                $display("FAIL misaligned_%0d edges=%0d err=%b rdata=%h want 1/1/0",
                         i, got_edges, got_err, got_rdata);
            end
            finish_resp();
        end
        checks++;
        if (dpi_lsu_pmem_pkg::rd_calls != rd0 || dpi_lsu_pmem_pkg::wr_calls != wr0) begin
            errors++;
            $display("FAIL misaligned_no_call reads=%0d writes=%0d want 0/0",
                     dpi_lsu_pmem_pkg::rd_calls - rd0, dpi_lsu_pmem_pkg::wr_calls - wr0);
        end
        checks++;
        if (ld_cnt !== m_ld[CW-1:0] || st_cnt !== m_st[CW-1:0]) begin
            errors++;
            $display("FAIL misaligned_counters ld=%0d st=%0d want %0d/%0d", ld_cnt, st_cnt, m_ld, m_st);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] first;
        start_req(1'b0, BASE, 2'd2, 1'b0, 32'h0);
        m_ld++;
        first = got_rdata;
        checks++;
        if (first !== 32'h8899_12BB) begin
            errors++;
            $display("FAIL hold_data got=%h want=889912bb", first);
        end
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            checks++;
            if (resp_valid !== 1'b1 || resp_rdata !== first || req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle_%0d vld=%b rdata=%h rdy=%b want 1/%h/0",
                         c, resp_valid, resp_rdata, req_ready, first);
            end
        end
        finish_resp();
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL hold_release rdy=%b vld=%b busy=%b want 1/0/0", req_ready, resp_valid, busy);
        end
    endtask

    task automatic test_reset_in_wait();
        int unsigned wr0;
        preset(BASE + 32'h10, 32'h1111_1111);
        wr0 = dpi_lsu_pmem_pkg::wr_calls;
        req_valid = 1'b1; req_wen = 1'b1; req_addr = BASE + 32'h10; req_size = 2'd2;
        req_unsigned = 1'b0; req_wdata = 32'hDEAD_BEEF;
        @(posedge clock); #1;
        req_valid = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL wait_busy got=%b want=1", busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || resp_valid !== 1'b0 || resp_rdata !== 32'h0 ||
            ld_cnt !== '0 || st_cnt !== '0) begin
            errors++;
            $display("FAIL async_reset busy=%b vld=%b rdata=%h ld=%0d st=%0d want all 0",
                     busy, resp_valid, resp_rdata, ld_cnt, st_cnt);
        end
        m_ld = 0;
        m_st = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        checks++;
        if (dpi_lsu_pmem_pkg::wr_calls != wr0) begin
            errors++;
            $display("FAIL dropped_store writes=%0d want 0", dpi_lsu_pmem_pkg::wr_calls - wr0);
        end
        start_req(1'b0, BASE + 32'h10, 2'd2, 1'b0, 32'h0);
        m_ld++;
        checks++;
        if (got_rdata !== 32'h1111_1111 || got_edges != LAT + 1) begin
            errors++;
            $display("FAIL after_reset rdata=%h edges=%0d want 11111111/%0d", got_rdata, got_edges, LAT + 1);
        end
        finish_resp();
        checks++;
        if (ld_cnt !== 4'd1 || st_cnt !== 4'd0) begin
            errors++;
            $display("FAIL after_reset_counters ld=%0d st=%0d want 1/0", ld_cnt, st_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] region;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int unsigned rd0;
        int unsigned wr0;
        int exp_rd;
        int exp_wr;
        int size;
        bit wen;
        bit uns;
        bit mis;
        region = BASE + 32'h100;
        for (int w = 0; w < 16; w++) preset(region + 4 * w, $urandom());
        rd0 = dpi_lsu_pmem_pkg::rd_calls;
        wr0 = dpi_lsu_pmem_pkg::wr_calls;
        exp_rd = 0;
        exp_wr = 0;
        for (int n = 0; n < 60; n++) begin
            wen   = 1'($urandom());
            uns   = 1'($urandom());
            size  = $urandom_range(0, 3);
            addr  = region + $urandom_range(0, 63);
            wdata = $urandom();
            mis   = ref_misaligned(addr, size);
            exp_rdata = (mis || wen) ? 32'h0 : ref_load(addr, size, uns);
            if (!mis) begin
                if (wen) begin
                    ref_store(addr, size, wdata);
                    m_st = (m_st < CMAX) ? m_st + 1 : CMAX;
                    exp_wr++;
                end else begin
                    m_ld = (m_ld < CMAX) ? m_ld + 1 : CMAX;
                    exp_rd++;
                end
            end
            start_req(wen, addr, 2'(size), uns, wdata);
            checks++;
            if (got_edges != (mis ? 1 : LAT + 1) || got_err !== mis || got_rdata !== exp_rdata) begin
                errors++;
                $display("FAIL rand_%0d wen=%0d size=%0d addr=%h got edges=%0d err=%b rdata=%h want %0d/%b/%h",
                         n, wen, size, addr, got_edges, got_err, got_rdata, mis ? 1 : LAT + 1, mis, exp_rdata);
            end
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #0;
            finish_resp();
            checks++;
            if (ld_cnt !== m_ld[CW-1:0] || st_cnt !== m_st[CW-1:0]) begin
                errors++;
                $display("FAIL rand_cnt_%0d ld=%0d st=%0d want %0d/%0d", n, ld_cnt, st_cnt, m_ld, m_st);
            end
        end
        checks++;
        if (dpi_lsu_pmem_pkg::rd_calls - rd0 != exp_rd || dpi_lsu_pmem_pkg::wr_calls - wr0 != exp_wr) begin
            errors++;
            $display("FAIL rand_calls reads=%0d writes=%0d want %0d/%0d",
                     dpi_lsu_pmem_pkg::rd_calls - rd0, dpi_lsu_pmem_pkg::wr_calls - wr0, exp_rd, exp_wr);
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < CMAX + 3; n++) begin
            start_req(1'b0, BASE, 2'd2, 1'b0, 32'h0);
            finish_resp();
            start_req(1'b1, BASE + 32'h20, 2'd2, 1'b0, $urandom());
            finish_resp();
        end
        m_ld = CMAX;
        m_st = CMAX;
        checks++;
        if (ld_cnt !== m_ld[CW-1:0] || st_cnt !== m_st[CW-1:0]) begin
            errors++;
            $display("FAIL saturation ld=%0d st=%0d want %0d/%0d", ld_cnt, st_cnt, m_ld, m_st);
        end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_size = '0;
        req_unsigned = 1'b0; req_wdata = '0; resp_ready = 1'b0;
        test_reset();
        test_loads();
        test_store();
        test_misaligned();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
